// File: rtl/icmp_packet_builder.sv
// ICMP transmit builder: latches header and payload on start, folds a 16-bit one's-complement
// checksum one word per cycle, then streams the packet one byte per valid/ready handshake.
`timescale 1ns/1ps
module icmp_packet_builder #(
  parameter int PAYLOAD_WORDS = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [7:0]                 icmp_type,
  input  logic [7:0]                 icmp_code,
  input  logic [15:0]                identifier,
  input  logic [15:0]                seq_num,
  input  logic [32*PAYLOAD_WORDS-1:0] payload,
  output logic [7:0]                 tx_data,
  output logic                       tx_valid,
  input  logic                       tx_ready,
  output logic                       tx_last,
  output logic                       busy,
  output logic                       done,
  output logic [15:0]                checksum_out
);
  localparam int N      = 3 + 2*PAYLOAD_WORDS;
  localparam int LEN    = 8 + 4*PAYLOAD_WORDS;
  localparam int PAY_W  = 32*PAYLOAD_WORDS;
  localparam int PKT_W  = 8*LEN;
  localparam int CALC_W = 16*N;
  localparam int WI_W   = $clog2(N+1);
  localparam int BI_W   = $clog2(LEN);

  typedef enum logic [1:0] {IDLE, CALC, SEND} state_t;

  state_t            state;
  logic [WI_W-1:0]   word_idx;
  logic [BI_W-1:0]   byte_idx;
  logic [15:0]       acc;
  logic [7:0]        type_q;
  logic [7:0]        code_q;
  logic [15:0]       id_q;
  logic [15:0]       seq_q;
  logic [PAY_W-1:0]  pay_q;
  logic [CALC_W-1:0] calc_sr;
  logic [PKT_W-1:0]  tx_sr;
  logic [PKT_W-1:0]  pkt;
  logic [16:0]       sum17;
  logic [15:0]       acc_next;
  logic              accept;
  logic              handshake;
  logic              calc_end;

  always_comb begin
    sum17     = {1'b0, acc} + {1'b0, calc_sr[CALC_W-1 -: 16]};
    acc_next  = sum17[15:0] + {15'd0, sum17[16]};
    pkt       = {type_q, code_q, ~acc, id_q, seq_q, pay_q};
    accept    = (state == IDLE) && start;
    handshake = (state == SEND) && tx_valid && tx_ready;
    calc_end  = (state == CALC) && (word_idx == WI_W'(N));
  end

  // Datapath storage: field snapshot, checksum word shifter, byte shifter (no reset needed)
  always_ff @(posedge clk) begin
    if (accept) begin
      type_q  <= icmp_type;
      code_q  <= icmp_code;
      id_q    <= identifier;
      seq_q   <= seq_num;
      pay_q   <= payload;
      calc_sr <= {icmp_type, icmp_code, identifier, seq_num, payload};
    end else if (state == CALC) begin
      calc_sr <= calc_sr << 16;
    end
    // tx_sr holds the bytes still to come after the one on tx_data
    if (calc_end)
      tx_sr <= pkt << 8;
    else if (handshake)
      tx_sr <= tx_sr << 8;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      word_idx     <= '0;
      byte_idx     <= '0;
      acc          <= '0;
      tx_data      <= '0;
      tx_valid     <= 1'b0;
      tx_last      <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      checksum_out <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            acc      <= '0;
            word_idx <= '0;
            busy     <= 1'b1;
            state    <= CALC;
          end
        end
        CALC: begin
          if (word_idx == WI_W'(N)) begin
            checksum_out <= ~acc;
            byte_idx     <= '0;
            tx_data      <= pkt[PKT_W-1 -: 8];
            tx_valid     <= 1'b1;
            tx_last      <= 1'b0;
            state        <= SEND;
          end else begin
            acc      <= acc_next;
            word_idx <= word_idx + 1'b1;
          end
        end
        SEND: begin
          if (tx_ready) begin
            if (byte_idx == BI_W'(LEN-1)) begin
              tx_data  <= '0;
              tx_valid <= 1'b0;
              tx_last  <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
              state    <= IDLE;
            end else begin
              byte_idx <= byte_idx + 1'b1;
              tx_data  <= tx_sr[PKT_W-1 -: 8];
              tx_last  <= (byte_idx == BI_W'(LEN-2));
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_icmp_packet_builder.sv
// Scoreboard bench for icmp_packet_builder: one instance with a single payload word, one with four.
`timescale 1ns/1ps
module tb_icmp_packet_builder;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, start_a, start_b, tx_ready_a, tx_ready_b;
  logic [7:0]   icmp_type, icmp_code;
  logic [15:0]  identifier, seq_num;
  logic [31:0]  payload_a;
  logic [127:0] payload_b;
  logic [7:0]   tx_data_a, tx_data_b;
  logic         tx_valid_a, tx_valid_b, tx_last_a, tx_last_b;
  logic         busy_a, busy_b, done_a, done_b;
  logic [15:0]  checksum_out_a, checksum_out_b;

  icmp_packet_builder #(.PAYLOAD_WORDS(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .icmp_type(icmp_type), .icmp_code(icmp_code),
    .identifier(identifier), .seq_num(seq_num), .payload(payload_a), .tx_data(tx_data_a),
    .tx_valid(tx_valid_a), .tx_ready(tx_ready_a), .tx_last(tx_last_a), .busy(busy_a),
    .done(done_a), .checksum_out(checksum_out_a));

  icmp_packet_builder #(.PAYLOAD_WORDS(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .icmp_type(icmp_type), .icmp_code(icmp_code),
    .identifier(identifier), .seq_num(seq_num), .payload(payload_b), .tx_data(tx_data_b),
    .tx_valid(tx_valid_b), .tx_ready(tx_ready_b), .tx_last(tx_last_b), .busy(busy_b),
    .done(done_b), .checksum_out(checksum_out_b));

  typedef struct packed {
    logic [7:0]  data;
    logic        last;
    logic        first;
    logic [15:0] ck;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   errors = 0;
  int   checks = 0;
  int   hs_a = 0, hs_b = 0, pkt_hs_a = 0, pkt_hs_b = 0;
  bit   pend_a = 0, pend_b = 0, stall_a = 0;
  logic [7:0] held_a = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_pkt(input bit to_b, input logic [7:0] t, input logic [7:0] c,
                          input logic [15:0] ck, input logic [15:0] id, input logic [15:0] sq,
                          input logic [127:0] pay, input int pw);
    logic [191:0] v;
    exp_t e;
    int len;
    v   = {t, c, ck, id, sq, pay};
    len = 8 + 4*pw;
    for (int i = 0; i < len; i++) begin
      e.data  = v[191-8*i -: 8];
      e.last  = (i == len-1);
      e.first = (i == 0);
      e.ck    = ck;
      if (to_b) qb.push_back(e);
      else      qa.push_back(e);
    end
  endtask

  task automatic scramble();
    icmp_type  = 8'($urandom);
    icmp_code  = 8'($urandom);
    identifier = 16'($urandom);
    seq_num    = 16'($urandom);
    payload_a  = $urandom;
    payload_b  = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic send_a(input logic [7:0] t, input logic [7:0] c, input logic [15:0] id,
                        input logic [15:0] sq, input logic [31:0] pay, input logic [15:0] ck);
    push_pkt(1'b0, t, c, ck, id, sq, {pay, 96'h0}, 1);
    icmp_type = t; icmp_code = c; identifier = id; seq_num = sq; payload_a = pay;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    scramble();
  endtask

  task automatic wait_done_a(input string name);
    int n = 0;
    while (!done_a && n < 200) begin @(posedge clk); #1; n++; end
    if (!done_a) begin
      checks++; errors++;
      $display("FAIL %s: done never seen within %0d cycles", name, n);
    end
  endtask

  task automatic wait_hs_a(input int target);
    int n = 0;
    while (hs_a < target && n < 100) begin @(posedge clk); #1; n++; end
    if (hs_a < target) begin
      checks++; errors++;
      $display("FAIL wait_hs: got %0d handshakes expected %0d", hs_a, target);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_tx_data"}, tx_data_a, 8'h00);
    chk({tag, "_tx_valid"}, tx_valid_a, 1'b0);
    chk({tag, "_tx_last"}, tx_last_a, 1'b0);
    chk({tag, "_busy"}, busy_a, 1'b0);
    chk({tag, "_done"}, done_a, 1'b0);
    chk({tag, "_checksum"}, checksum_out_a, 16'h0000);
  endtask

  // Monitor for instance A: byte scoreboard, done timing, stall stability
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      pend_a = 0; pkt_hs_a = 0; stall_a = 0;
    end else begin
      if (pend_a) begin
        chk("done_a", done_a, 1'b1);
        chk("busy_after_done_a", busy_a, 1'b0);
        pend_a = 0;
      end else if (done_a) begin
        chk("spurious_done_a", done_a, 1'b0);
      end
      if (stall_a) begin
        chk("hold_valid_a", tx_valid_a, 1'b1);
        chk("hold_data_a", tx_data_a, held_a);
      end
      stall_a = tx_valid_a && !tx_ready_a;
      held_a  = tx_data_a;
      if (tx_valid_a && tx_ready_a) begin
        hs_a++;
        if (qa.size() == 0) begin
          checks++; errors++;
          $display("FAIL extra_byte_a: got %0h expected no byte", tx_data_a);
        end else begin
          e = qa.pop_front();
          chk("data_a", tx_data_a, e.data);
          chk("last_a", tx_last_a, e.last);
          if (e.first) chk("checksum_a", checksum_out_a, e.ck);
          if (e.last) begin
            chk("pkt_len_a", pkt_hs_a + 1, 12);
            pkt_hs_a = 0;
            pend_a = 1;
          end else begin
            pkt_hs_a++;
          end
        end
      end
    end
  end

  // Monitor for instance B
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      pend_b = 0; pkt_hs_b = 0;
    end else begin
      if (pend_b) begin
        chk("done_b", done_b, 1'b1);
        pend_b = 0;
      end else if (done_b) begin
        chk("spurious_done_b", done_b, 1'b0);
      end
      if (tx_valid_b && tx_ready_b) begin
        hs_b++;
        if (qb.size() == 0) begin
          checks++; errors++;
          $display("FAIL extra_byte_b: got %0h expected no byte", tx_data_b);
        end else begin
          e = qb.pop_front();
          chk("data_b", tx_data_b, e.data);
          chk("last_b", tx_last_b, e.last);
          if (e.first) chk("checksum_b", checksum_out_b, e.ck);
          if (e.last) begin
            chk("pkt_len_b", pkt_hs_b + 1, 24);
            pkt_hs_b = 0;
            pend_b = 1;
          end else begin
            pkt_hs_b++;
          end
        end
      end
    end
  end

  initial begin
    int lat;
    int base;
    int n;
    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; tx_ready_a = 1'b1; tx_ready_b = 1'b1;
    icmp_type = '0; icmp_code = '0; identifier = '0; seq_num = '0; payload_a = '0; payload_b = '0;
    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Echo request with first-byte latency
    send_a(8'h08, 8'h00, 16'h0001, 16'h0001, 32'hDEADBEEF, 16'h5A60);
    lat = 0;
    while (!tx_valid_a && lat < 40) begin @(posedge clk); #1; lat++; end
    chk("latency_a", lat, 6);
    wait_done_a("echo");

    // All-zero fields and end-around carry
    send_a(8'h00, 8'h00, 16'h0000, 16'h0000, 32'h0, 16'hFFFF);
    wait_done_a("zeros");
    send_a(8'hFF, 8'hFF, 16'hFFFF, 16'h0001, 32'h0, 16'hFFFE);
    wait_done_a("carry");

    // Backpressure while byte 5 is presented
    base = hs_a;
    send_a(8'h08, 8'h00, 16'h0001, 16'h0001, 32'hDEADBEEF, 16'h5A60);
    wait_hs_a(base + 5);
    tx_ready_a = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("bp_byte5", tx_data_a, 8'h01);
    tx_ready_a = 1'b1;
    wait_done_a("backpressure");

    // Start while busy is ignored; start in the done cycle is accepted
    send_a(8'h08, 8'h00, 16'h0001, 16'h0001, 32'hDEADBEEF, 16'h5A60);
    repeat (8) @(posedge clk);
    #1;
    start_a = 1'b1; scramble();
    @(posedge clk); #1;
    start_a = 1'b0; scramble();
    wait_done_a("busy_start");
    send_a(8'hFF, 8'hFF, 16'hFFFF, 16'h0001, 32'h0, 16'hFFFE);
    chk("busy_reassert", busy_a, 1'b1);
    wait_done_a("back_to_back");

    // Reset while byte 7 is presented aborts the packet
    base = hs_a;
    send_a(8'h08, 8'h00, 16'h0001, 16'h0001, 32'hDEADBEEF, 16'h5A60);
    wait_hs_a(base + 7);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("abort");
    qa.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("abort_no_done", done_a, 1'b0);
    send_a(8'h08, 8'h00, 16'h0001, 16'h0001, 32'hDEADBEEF, 16'h5A60);
    wait_done_a("after_abort");

    // Four payload words on the second instance
    push_pkt(1'b1, 8'h08, 8'h00, 16'h8187, 16'h0001, 16'h0001, {4{32'hDEADBEEF}}, 4);
    icmp_type = 8'h08; icmp_code = 8'h00; identifier = 16'h0001; seq_num = 16'h0001;
    payload_b = {4{32'hDEADBEEF}};
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    scramble();
    lat = 0;
    while (!tx_valid_b && lat < 60) begin @(posedge clk); #1; lat++; end
    chk("latency_b", lat, 12);
    n = 0;
    while (!done_b && n < 200) begin @(posedge clk); #1; n++; end
    chk("done_seen_b", done_b, 1'b1);

    repeat (3) @(posedge clk);
    #1;
    chk("queue_a_empty", qa.size(), 0);
    chk("queue_b_empty", qb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
